// File: rtl/traffic_cmd_gen_if.sv
// traffic_cmd_gen_if: raw push-button inputs and clean command outputs of
// the traffic-light command generator, bundled for port connection.
interface traffic_cmd_gen_if;
    logic       btn_start;
    logic       btn_pause;
    logic       btn_stopa;
    logic       btn_stopb;
    logic       btn_clear;
    logic       start;
    logic       pause;
    logic       stopa;
    logic       stopb;
    logic [1:0] mode;

    modport master (
        output btn_start, btn_pause, btn_stopa, btn_stopb, btn_clear,
        input  start, pause, stopa, stopb, mode
    );

    modport slave (
        input  btn_start, btn_pause, btn_stopa, btn_stopb, btn_clear,
        output start, pause, stopa, stopb, mode
    );
endinterface

// File: rtl/traffic_cmd_gen.sv
// traffic_cmd_gen: synchronises and debounces five push-buttons and runs the
// IDLE/RUN/PAUSED/STOPPED command FSM for the traffic-light controller.
// Optional feature: define CMD_AUTO_RESUME_EN to make a clear return to the
// state that was active before STOPPED (RUN or PAUSED) instead of always RUN.
module traffic_cmd_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input logic              clk,
    input logic              rst,
    traffic_cmd_gen_if.slave bus
);
    localparam int unsigned       CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        STOPPED = 2'd3
    } state_t;

    // Lane order: 0 start, 1 pause, 2 stopa, 3 stopb, 4 clear.
    logic [4:0]       raw;
    logic [4:0]       sync1, sync2, db, db_q, ev;
    logic [CNT_W-1:0] cnt [5];

    assign raw = {bus.btn_clear, bus.btn_stopb, bus.btn_stopa,
                  bus.btn_pause, bus.btn_start};

    // Synchronise, debounce and edge-detect every button lane.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            db_q  <= '0;
            ev    <= '0;
            for (int unsigned i = 0; i < 5; i++) cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            db_q  <= db;
            ev    <= db & ~db_q;
            for (int unsigned i = 0; i < 5; i++) begin
                if (sync2[i] != db[i]) begin
                    if (cnt[i] == CNT_MAX) begin
                        db[i]  <= sync2[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    state_t state, state_nx;
    logic   start_q, start_nx;
    logic   pause_q, pause_nx;
    logic   stopa_q, stopa_nx;
    logic   stopb_q, stopb_nx;
`ifdef CMD_AUTO_RESUME_EN
    state_t resume, resume_nx;
`endif

    // FSM state and registered command outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            start_q <= 1'b0;
            pause_q <= 1'b0;
            stopa_q <= 1'b0;
            stopb_q <= 1'b0;
`ifdef CMD_AUTO_RESUME_EN
            resume  <= RUN;
`endif
        end else begin
            state   <= state_nx;
            start_q <= start_nx;
            pause_q <= pause_nx;
            stopa_q <= stopa_nx;
            stopb_q <= stopb_nx;
`ifdef CMD_AUTO_RESUME_EN
            resume  <= resume_nx;
`endif
        end
    end

    // Next state with priority stop > clear > pause > start; lower-priority
    // events in the same cycle are simply dropped.
    always_comb begin
        state_nx = state;
        start_nx = 1'b0;
        stopa_nx = stopa_q;
        stopb_nx = stopb_q;
`ifdef CMD_AUTO_RESUME_EN
        resume_nx = resume;
`endif
        if (ev[2] || ev[3]) begin
            state_nx = STOPPED;
            stopa_nx = stopa_q | ev[2];
            stopb_nx = stopb_q | ev[3];
`ifdef CMD_AUTO_RESUME_EN
            if (state != STOPPED) resume_nx = (state == PAUSED) ? PAUSED : RUN;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (ev[0]) begin
                        state_nx = RUN;
                        start_nx = 1'b1;
                    end
                end
                RUN:    if (ev[1]) state_nx = PAUSED;
                PAUSED: if (ev[1]) state_nx = RUN;
                STOPPED: begin
                    if (ev[4]) begin
`ifdef CMD_AUTO_RESUME_EN
                        state_nx = resume;
`else
                        state_nx = RUN;
`endif
                        stopa_nx = 1'b0;
                        stopb_nx = 1'b0;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
        pause_nx = (state_nx == PAUSED);
    end

    assign bus.start = start_q;
    assign bus.pause = pause_q;
    assign bus.stopa = stopa_q;
    assign bus.stopb = stopb_q;
    assign bus.mode  = state;
endmodule
